// File: rtl/led_matrix_scroller_pkg.sv
// Shared definitions for the LED matrix scroller.
//   MODE_*   : scroll direction encodings driven on the mode input
//   state_e  : control FSM states
//   diag_row : power-up pattern for one row (active-low, one lit LED per row)
package led_matrix_scroller_pkg;

  localparam logic [1:0] MODE_LEFT  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_UP    = 2'b10;
  localparam logic [1:0] MODE_DOWN  = 2'b11;

  // Widest row diag_row can build; callers keep the low COLS bits.
  localparam int MAX_COLS = 64;

  typedef enum logic [1:0] {PAUSE, RUN, STEP} state_e;

  // Row r lights column (cols-1-r); rows past the last column stay dark.
  function automatic logic [MAX_COLS-1:0] diag_row(input int r, input int cols);
    logic [MAX_COLS-1:0] v;
    v = '1;
    if (r < cols) v = ~(MAX_COLS'(1) << (cols - 1 - r));
    return v;
  endfunction

endpackage

// File: rtl/led_matrix_scroller_if.sv
// Control/data bundle between a pattern source and the scroller.
//   master : drives mode, run, step_req and the row write port
//   slave  : the scroller; returns wr_ready, frame, tick, step_count
interface led_matrix_scroller_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = $clog2(ROWS)
);
  logic [1:0]           mode;
  logic                 run;
  logic                 step_req;
  logic                 wr_en;
  logic [RW-1:0]        wr_row;
  logic [COLS-1:0]      wr_data;
  logic                 wr_ready;
  logic [ROWS*COLS-1:0] frame;
  logic                 tick;
  logic [15:0]          step_count;

  modport master (
    output mode, run, step_req, wr_en, wr_row, wr_data,
    input  wr_ready, frame, tick, step_count
  );

  modport slave (
    input  mode, run, step_req, wr_en, wr_row, wr_data,
    output wr_ready, frame, tick, step_count
  );
endinterface

// File: rtl/led_matrix_scroller_step_prescaler.sv
// Step-rate divider: counts 0..DIV-1 while enabled, held at 0 while clear.
//   sys_clock, sys_reset : clock, synchronous active-high reset
//   clear                : force count to 0
//   enable               : advance the count
//   tick                 : high for the one cycle the count sits at DIV-1
module step_prescaler #(
  parameter int DIV = 4
) (
  input  logic sys_clock,
  input  logic sys_reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int            CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge sys_clock) begin
    if (sys_reset || clear) cnt <= '0;
    else if (enable)        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/led_matrix_scroller.sv
// ROWS x COLS frame buffer that rotates left/right/up/down at a programmable
// rate, with run/pause, single-step and per-row pattern writes.
//   sys_clock, sys_reset : clock, synchronous active-high reset
//   bus (slave)          : mode/run/step_req in, row write port, frame,
//                          tick and step_count out
module led_matrix_scroller
  import led_matrix_scroller_pkg::*;
#(
  parameter int CLK_HZ  = 27_000_000,
  parameter int STEP_HZ = 10,
  parameter int ROWS    = 8,
  parameter int COLS    = 8
) (
  input logic                  sys_clock,
  input logic                  sys_reset,
  led_matrix_scroller_if.slave bus
);
  localparam int            DIV     = CLK_HZ / STEP_HZ;
  localparam int            RW      = $clog2(ROWS);
  localparam logic [RW:0]   ROW_LIM = (RW + 1)'(ROWS);

  state_e                   state, state_nx;
  logic                     pre_tick, shift, wr_fire, tick_q;
  logic [15:0]              step_cnt;
  logic [ROWS-1:0][COLS-1:0] rows_q, diag, rot_l, rot_r, rot_u, rot_d, shifted;

  step_prescaler #(.DIV(DIV)) u_presc (
    .sys_clock (sys_clock),
    .sys_reset (sys_reset),
    .clear     (state != RUN),
    .enable    (state == RUN),
    .tick      (pre_tick)
  );

  // Candidate next frames for each direction, one row per generate lane.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam int                  R_UP = (r + 1) % ROWS;
    localparam int                  R_DN = (r + ROWS - 1) % ROWS;
    localparam logic [MAX_COLS-1:0] DIAG = diag_row(r, COLS);
    assign diag[r]  = DIAG[COLS-1:0];
    assign rot_l[r] = {rows_q[r][COLS-2:0], rows_q[r][COLS-1]};
    assign rot_r[r] = {rows_q[r][0], rows_q[r][COLS-1:1]};
    assign rot_u[r] = rows_q[R_UP];
    assign rot_d[r] = rows_q[R_DN];
  end

  always_comb begin
    shifted = rot_l;
    unique case (bus.mode)
      MODE_LEFT:  shifted = rot_l;
      MODE_RIGHT: shifted = rot_r;
      MODE_UP:    shifted = rot_u;
      MODE_DOWN:  shifted = rot_d;
      default:    shifted = rot_l;
    endcase
  end

  // run wins over step_req in PAUSE; step_req is only looked at in PAUSE.
  always_comb begin
    state_nx = state;
    shift    = 1'b0;
    unique case (state)
      PAUSE: begin
        if (bus.run)           state_nx = RUN;
        else if (bus.step_req) state_nx = STEP;
      end
      RUN: begin
        shift = pre_tick;
        if (!bus.run) state_nx = PAUSE;
      end
      STEP: begin
        shift    = 1'b1;
        state_nx = PAUSE;
      end
      default: state_nx = PAUSE;
    endcase
  end

  // A shift owns the frame for its cycle; the writer retries afterwards.
  assign bus.wr_ready = !shift;
  assign wr_fire      = bus.wr_en && !shift && ({1'b0, bus.wr_row} < ROW_LIM);

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      state    <= PAUSE;
      rows_q   <= diag;
      tick_q   <= 1'b0;
      step_cnt <= '0;
    end else begin
      state  <= state_nx;
      tick_q <= shift;
      if (shift) begin
        rows_q   <= shifted;
        step_cnt <= step_cnt + 16'd1;
      end else if (wr_fire) begin
        rows_q[bus.wr_row] <= bus.wr_data;
      end
    end
  end

  assign bus.frame      = rows_q;
  assign bus.tick       = tick_q;
  assign bus.step_count = step_cnt;
endmodule

// File: tb/tb_led_matrix_scroller.sv
module tb_led_matrix_scroller;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DIV  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_matrix_scroller_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
  led_matrix_scroller #(.CLK_HZ(40), .STEP_HZ(10), .ROWS(ROWS), .COLS(COLS)) dut (
    .sys_clock (clk), .sys_reset (rst), .bus (bus));

  // Non-power-of-two row count so out-of-range row indices are representable.
  led_matrix_scroller_if #(.ROWS(6), .COLS(8)) bus2 ();
  led_matrix_scroller #(.CLK_HZ(40), .STEP_HZ(10), .ROWS(6), .COLS(8)) dut2 (
    .sys_clock (clk), .sys_reset (rst), .bus (bus2));

  int pass = 0;
  int tot  = 0;

  // Reference: frame as a grid of bits on a torus, count modulo 2^16.
  logic [7:0] mrow [ROWS];
  int         mcnt;

  typedef struct {
    bit         op;        // 0 = step, 1 = row write
    logic [1:0] mode;
    logic [2:0] row;
    logic [7:0] data;
    logic [7:0] exp_row0;
    int         exp_cnt;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic m_reset();
    for (int r = 0; r < ROWS; r++) mrow[r] = ~(8'h80 >> r);
    mcnt = 0;
  endtask

  // Translate the whole picture by (dr, dc) with wrap-around.
  task automatic m_shift(input logic [1:0] m);
    logic [7:0] o [ROWS];
    int dr, dc;
    o  = mrow;
    dr = (m == 2'b10) ? 1 : (m == 2'b11) ? ROWS - 1 : 0;
    dc = (m == 2'b00) ? COLS - 1 : (m == 2'b01) ? 1 : 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mrow[r][c] = o[(r + dr) % ROWS][(c + dc) % COLS];
    mcnt = (mcnt + 1) % 65536;
  endtask

  function automatic logic [63:0] mframe();
    logic [63:0] f;
    for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = mrow[r];
    return f;
  endfunction

  task automatic chk_model(input string nm);
    chk({nm, "_frame"}, bus.frame, mframe());
    chk({nm, "_count"}, 64'(bus.step_count), 64'(mcnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic do_step(input logic [1:0] m);
    int seen = 0;
    bus.mode = m; bus.step_req = 1'b1;
    @(negedge clk);
    bus.step_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.tick) seen++;
      @(negedge clk);
    end
    chk("step_one_tick", 64'(seen), 64'd1);
    m_shift(m);
  endtask

  // Only used while paused, where every write is accepted.
  task automatic do_write(input logic [2:0] row, input logic [7:0] d);
    bit ok = 0;
    bus.wr_en = 1'b1; bus.wr_row = row; bus.wr_data = d;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (bus.wr_ready) ok = 1;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    chk("write_accepted", 64'(ok), 64'd1);
    if (ok) mrow[row] = d;
  endtask

  // Enter RUN from PAUSE, expect k ticks spaced DIV apart, then pause.
  task automatic run_ticks(input logic [1:0] m, input int k);
    int seen = 0, last = 0, cyc = 0;
    bus.mode = m; bus.run = 1'b1;
    while (seen < k && cyc < k * DIV + 8) begin
      @(negedge clk); cyc++;
      if (bus.tick) begin
        seen++;
        m_shift(m);
        chk("tick_spacing", 64'(cyc - last), 64'((seen == 1) ? DIV + 1 : DIV));
        last = cyc;
      end
    end
    bus.run = 1'b0;
    chk("run_tick_count", 64'(seen), 64'(k));
    @(negedge clk);
    @(negedge clk);
    chk("no_tick_after_pause", 64'(bus.tick), 64'd0);
  endtask

  initial begin
    bus.mode = 2'b00; bus.run = 1'b0; bus.step_req = 1'b0;
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0;
    bus2.mode = 2'b00; bus2.run = 1'b0; bus2.step_req = 1'b0;
    bus2.wr_en = 1'b0; bus2.wr_row = '0; bus2.wr_data = '0;

    tbl[0] = '{op: 0, mode: 2'b00, row: 0, data: 0,     exp_row0: 8'hFE, exp_cnt: 1};
    tbl[1] = '{op: 0, mode: 2'b01, row: 0, data: 0,     exp_row0: 8'h7F, exp_cnt: 2};
    tbl[2] = '{op: 0, mode: 2'b10, row: 0, data: 0,     exp_row0: 8'hBF, exp_cnt: 3};
    tbl[3] = '{op: 0, mode: 2'b11, row: 0, data: 0,     exp_row0: 8'h7F, exp_cnt: 4};
    tbl[4] = '{op: 1, mode: 2'b00, row: 3, data: 8'h00, exp_row0: 8'h7F, exp_cnt: 4};
    tbl[5] = '{op: 0, mode: 2'b11, row: 0, data: 0,     exp_row0: 8'hFE, exp_cnt: 5};
    tbl[6] = '{op: 0, mode: 2'b01, row: 0, data: 0,     exp_row0: 8'h7F, exp_cnt: 6};

    // Reset state
    do_reset();
    chk_model("reset");
    chk("reset_row0", 64'(bus.frame[7:0]), 64'h7F);
    chk("reset_tick", 64'(bus.tick), 64'd0);
    chk("reset_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("reset_frame2", bus2.frame[47:0], 48'hFBF7EFDFBF7F);

    // Paused step/write vectors
    foreach (tbl[i]) begin
      if (tbl[i].op) do_write(tbl[i].row, tbl[i].data);
      else           do_step(tbl[i].mode);
      chk("vec_row0", 64'(bus.frame[7:0]), 64'(tbl[i].exp_row0));
      chk("vec_count", 64'(bus.step_count), 64'(tbl[i].exp_cnt));
      chk_model("vec");
    end

    // RUN left: first tick 4 cycles after entry, row0 7F -> FE
    do_reset();
    run_ticks(2'b00, 3);
    chk_model("run_left");
    do_reset();
    run_ticks(2'b00, 1);
    chk("run_left_row0", 64'(bus.frame[7:0]), 64'hFE);

    // Eight ups bring the diagonal back
    do_reset();
    run_ticks(2'b10, 8);
    chk("up8_frame", bus.frame, 64'hFEFDFBF7EFDFBF7F);
    chk("up8_count", 64'(bus.step_count), 64'd8);
    do_step(2'b01);
    chk("right_row0", 64'(bus.frame[7:0]), 64'hBF);
    chk_model("right");

    // step_req held in RUN adds nothing
    begin
      int seen = 0;
      bus.mode = 2'b01; bus.run = 1'b1; bus.step_req = 1'b1;
      for (int i = 1; i <= 13; i++) begin
        @(negedge clk);
        if (bus.tick) begin seen++; m_shift(2'b01); end
      end
      bus.run = 1'b0; bus.step_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (bus.tick) seen++;
      end
      chk("run_step_held_ticks", 64'(seen), 64'd3);
      chk_model("run_step_held");
    end

    // Write collides with a shift: dropped, then accepted on retry
    bus.mode = 2'b00; bus.run = 1'b1;
    repeat (4) @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_row = 3'd3; bus.wr_data = 8'h00;
    chk("wr_ready_on_shift", 64'(bus.wr_ready), 64'd0);
    @(negedge clk);
    chk("collide_tick", 64'(bus.tick), 64'd1);
    m_shift(2'b00);
    chk_model("collide_dropped");
    chk("wr_ready_after_shift", 64'(bus.wr_ready), 64'd1);
    @(negedge clk);
    mrow[3] = 8'h00;
    chk_model("collide_retry");
    chk("collide_retry_tick", 64'(bus.tick), 64'd0);
    bus.wr_en = 1'b0; bus.run = 1'b0;
    @(negedge clk); @(negedge clk);

    // Randomised mix against the model
    for (int it = 0; it < 30; it++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 0)      do_step(2'($urandom_range(0, 3)));
      else if (op == 1) do_write(3'($urandom_range(0, 7)), 8'($urandom));
      else              run_ticks(2'($urandom_range(0, 3)), $urandom_range(1, 3));
      chk_model("rand");
    end

    // Out-of-range row writes are ignored (6-row instance)
    for (int w = 6; w < 8; w++) begin
      bus2.wr_en = 1'b1; bus2.wr_row = 3'(w); bus2.wr_data = 8'h00;
      @(negedge clk);
    end
    bus2.wr_en = 1'b0;
    @(negedge clk);
    chk("oob_write_ignored", bus2.frame[47:0], 48'hFBF7EFDFBF7F);
    bus2.wr_en = 1'b1; bus2.wr_row = 3'd5; bus2.wr_data = 8'h3C;
    @(negedge clk);
    bus2.wr_en = 1'b0;
    @(negedge clk);
    chk("last_row_write", bus2.frame[47:0], 48'h3CF7EFDFBF7F);

    // Counter wrap: preset to 0xFFFF, one step rolls to 0
    force dut.step_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.step_cnt;
    @(negedge clk);
    chk("preset_count", 64'(bus.step_count), 64'hFFFF);
    mcnt = 65535;
    do_step(2'b10);
    chk("wrap_count", 64'(bus.step_count), 64'd0);
    chk_model("wrap");

    // Reset mid-RUN between ticks
    bus.mode = 2'b00; bus.run = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    chk_model("midrun_reset");
    chk("midrun_reset_tick", 64'(bus.tick), 64'd0);
    chk("midrun_reset_ready", 64'(bus.wr_ready), 64'd1);
    begin
      int first = 0;
      for (int j = 1; j <= 8 && first == 0; j++) begin
        @(negedge clk);
        if (bus.tick) first = j;
      end
      bus.run = 1'b0;
      chk("post_reset_first_tick", 64'(first), 64'd5);
      m_shift(2'b00);
      @(negedge clk); @(negedge clk);
      chk_model("post_reset");
    end

    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
